// File: rtl/retire_monitor.sv
// Retire-side observer for the dual-issue RV32I core: run/halt/timeout control,
// cycle and instret counters, and an in-order FIFO of per-instruction retire records.
module retire_monitor #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [CNT_W-1:0] max_cycles,
   input  logic             ex0_valid,
   input  logic [31:0]      ex0_pc,
   input  logic [31:0]      ex0_instr,
   input  logic [31:0]      ex0_result,
   input  logic             ex1_valid,
   input  logic [31:0]      ex1_pc,
   input  logic [31:0]      ex1_instr,
   input  logic [31:0]      ex1_result,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [31:0]      rec_pc,
   output logic [31:0]      rec_instr,
   output logic [31:0]      rec_result,
   output logic             rec_slot,
   output logic [CNT_W-1:0] rec_cycle,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic             overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
   localparam logic [1:0] CAUSE_ECALL   = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

   logic [1:0]       state_q, state_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             overflow_q, overflow_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   logic [31:0]      pc_mem_q    [FIFO_DEPTH];
   logic [31:0]      pc_mem_d    [FIFO_DEPTH];
   logic [31:0]      instr_mem_q [FIFO_DEPTH];
   logic [31:0]      instr_mem_d [FIFO_DEPTH];
   logic [31:0]      res_mem_q   [FIFO_DEPTH];
   logic [31:0]      res_mem_d   [FIFO_DEPTH];
   logic             slot_mem_q  [FIFO_DEPTH];
   logic             slot_mem_d  [FIFO_DEPTH];
   logic [CNT_W-1:0] cyc_mem_q   [FIFO_DEPTH];
   logic [CNT_W-1:0] cyc_mem_d   [FIFO_DEPTH];

   logic             run;
   logic             eff0, eff1;
   logic             halt0, halt1;
   logic             timeout;
   logic             pop;
   logic [OCC_W-1:0] free_slots;
   logic             has_first, has_second;
   logic             push_first, push_second;
   logic [1:0]       n_push;
   logic [PTR_W-1:0] wr_ptr_next;
   logic [31:0]      first_pc, first_instr, first_result;
   logic             first_slot;

   // Slot1 is squashed when an older slot0 halt retires in the same cycle.
   assign run   = (state_q == ST_RUN);
   assign eff0  = run && ex0_valid;
   assign halt0 = eff0 && ((ex0_instr == INSTR_EBREAK) || (ex0_instr == INSTR_ECALL));
   assign eff1  = run && ex1_valid && !halt0;
   assign halt1 = eff1 && ((ex1_instr == INSTR_EBREAK) || (ex1_instr == INSTR_ECALL));

   assign timeout = (max_cycles != '0) && (cycle_q == (max_cycles - CNT_W'(1)));

   assign rec_valid  = (occ_q != '0);
   assign pop        = rec_valid && rec_ready;
   assign free_slots = DEPTH_OCC - occ_q;

   // Space is judged on start-of-cycle occupancy; a same-cycle pop frees nothing.
   assign has_first   = eff0 || eff1;
   assign has_second  = eff0 && eff1;
   assign push_first  = has_first && (free_slots != '0);
   assign push_second = has_second && (free_slots >= OCC_W'(2));
   assign n_push      = {1'b0, push_first} + {1'b0, push_second};
   assign wr_ptr_next = wr_ptr_q + PTR_W'(1);

   assign first_pc     = eff0 ? ex0_pc     : ex1_pc;
   assign first_instr  = eff0 ? ex0_instr  : ex1_instr;
   assign first_result = eff0 ? ex0_result : ex1_result;
   assign first_slot   = !eff0;

   always_comb begin
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      res_mem_d   = res_mem_q;
      slot_mem_d  = slot_mem_q;
      cyc_mem_d   = cyc_mem_q;
      if (push_first) begin
         pc_mem_d[wr_ptr_q]    = first_pc;
         instr_mem_d[wr_ptr_q] = first_instr;
         res_mem_d[wr_ptr_q]   = first_result;
         slot_mem_d[wr_ptr_q]  = first_slot;
         cyc_mem_d[wr_ptr_q]   = cycle_q;
      end
      if (push_second) begin
         pc_mem_d[wr_ptr_next]    = ex1_pc;
         instr_mem_d[wr_ptr_next] = ex1_instr;
         res_mem_d[wr_ptr_next]   = ex1_result;
         slot_mem_d[wr_ptr_next]  = 1'b1;
         cyc_mem_d[wr_ptr_next]   = cycle_q;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(n_push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      occ_d      = occ_q + OCC_W'(n_push) - OCC_W'(pop);
      overflow_d = overflow_q
                   || (has_first && !push_first)
                   || (has_second && !push_second);
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      cycle_d   = cycle_q;
      instret_d = instret_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_RUN;
         end
         ST_RUN: begin
            cycle_d   = cycle_q + CNT_W'(1);
            instret_d = instret_q + CNT_W'(eff0) + CNT_W'(eff1);
            if (halt0) begin
               state_d = ST_DRAIN;
               cause_d = (ex0_instr == INSTR_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
            end else if (halt1) begin
               state_d = ST_DRAIN;
               cause_d = (ex1_instr == INSTR_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
            end else if (timeout) begin
               state_d = ST_DRAIN;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_DRAIN: begin
            // No pushes happen here, so occ_d already accounts for this cycle's pop.
            if (occ_d == '0) state_d = ST_DONE;
         end
         default: begin
            state_d = ST_DONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cause_q    <= CAUSE_NONE;
         cycle_q    <= '0;
         instret_q  <= '0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
            res_mem_q[i]   <= '0;
            slot_mem_q[i]  <= 1'b0;
            cyc_mem_q[i]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         cycle_q     <= cycle_d;
         instret_q   <= instret_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
         res_mem_q   <= res_mem_d;
         slot_mem_q  <= slot_mem_d;
         cyc_mem_q   <= cyc_mem_d;
      end
   end

   assign rec_pc      = pc_mem_q[rd_ptr_q];
   assign rec_instr   = instr_mem_q[rd_ptr_q];
   assign rec_result  = res_mem_q[rd_ptr_q];
   assign rec_slot    = slot_mem_q[rd_ptr_q];
   assign rec_cycle   = cyc_mem_q[rd_ptr_q];
   assign cycle_count = cycle_q;
   assign instret     = instret_q;
   assign halted      = (state_q == ST_DONE);
   assign halt_cause  = cause_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Directed bench for retire_monitor: per-cycle vector table for dual retire and halt
// squash, plus hand-written timeout, overflow and backpressure sequences.
module tb_retire_monitor;

   localparam int CNT_W = 32;
   localparam logic [31:0] I_ADDI   = 32'h0010_0093;
   localparam logic [31:0] I_ADD    = 32'h0020_81b3;
   localparam logic [31:0] I_EBREAK = 32'h0010_0073;
   localparam logic [31:0] I_ECALL  = 32'h0000_0073;
   localparam logic [31:0] RES_OFS  = 32'h0000_1000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic [CNT_W-1:0] max_cycles;
   logic             ex0_valid, ex1_valid;
   logic [31:0]      ex0_pc, ex0_instr, ex0_result;
   logic [31:0]      ex1_pc, ex1_instr, ex1_result;
   logic             rec_valid, rec_ready, rec_slot;
   logic [31:0]      rec_pc, rec_instr, rec_result;
   logic [CNT_W-1:0] rec_cycle, cycle_count, instret;
   logic             halted, overflow;
   logic [1:0]       halt_cause;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] cyc_q[$];

   typedef struct {
      logic        en;
      logic        v0;
      logic [31:0] pc0;
      logic [31:0] in0;
      logic        v1;
      logic [31:0] pc1;
      logic [31:0] in1;
      logic        rdy;
      logic        e_valid;
      logic [31:0] e_pc;
      logic        e_slot;
      logic [31:0] e_rcyc;
      logic [31:0] e_instret;
      logic [31:0] e_cycle;
      logic        e_halted;
      logic [1:0]  e_cause;
   } vec_t;

   vec_t vecs[7];

   retire_monitor #(.FIFO_DEPTH(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .max_cycles(max_cycles),
      .ex0_valid(ex0_valid), .ex0_pc(ex0_pc), .ex0_instr(ex0_instr), .ex0_result(ex0_result),
      .ex1_valid(ex1_valid), .ex1_pc(ex1_pc), .ex1_instr(ex1_instr), .ex1_result(ex1_result),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pc(rec_pc), .rec_instr(rec_instr),
      .rec_result(rec_result), .rec_slot(rec_slot), .rec_cycle(rec_cycle),
      .cycle_count(cycle_count), .instret(instret), .halted(halted),
      .halt_cause(halt_cause), .overflow(overflow)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running, want finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [31:0] pc0, input logic [31:0] in0,
                        input logic v1, input logic [31:0] pc1, input logic [31:0] in1);
      ex0_valid  = v0;
      ex0_pc     = pc0;
      ex0_instr  = in0;
      ex0_result = pc0 + RES_OFS;
      ex1_valid  = v1;
      ex1_pc     = pc1;
      ex1_instr  = in1;
      ex1_result = pc1 + RES_OFS;
   endtask

   task automatic do_reset;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      enable     = 1'b0;
      rec_ready  = 1'b0;
      max_cycles = '0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      cyc_q.delete();
   endtask

   task automatic start_run;
      enable = 1'b1;
      tick();
      enable = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Pops the FIFO with rec_ready held high and matches each head against exp_q.
   task automatic drain_check(input string name);
      rec_ready = 1'b1;
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
         if (rec_valid) check({name, "_pc"}, rec_pc, exp_q.pop_front());
         tick();
      end
      check({name, "_left"}, 32'(exp_q.size()), 32'd0);
      check({name, "_empty"}, 32'(rec_valid), 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic        stalled;
      logic [31:0] held_pc, held_res, held_cyc, nxt_pc, run_cyc, n_pushed;
      logic        v;

      // Reset and idle: retires are ignored before enable.
      do_reset();
      check("rst_valid", 32'(rec_valid), 32'd0);
      check("rst_pc", rec_pc, 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      drive(1'b1, 32'h10, I_ADDI, 1'b0, 32'h0, 32'h0);
      repeat (5) tick();
      check("idle_valid", 32'(rec_valid), 32'd0);
      check("idle_instret", instret, 32'd0);
      check("idle_cycle", cycle_count, 32'd0);
      check("idle_halted", 32'(halted), 32'd0);
      check("idle_cause", 32'(halt_cause), 32'd0);
      check("idle_ovf", 32'(overflow), 32'd0);
      check("idle_rcyc", rec_cycle, 32'd0);
      check("idle_result", rec_result, 32'd0);

      // Dual retire ordering then halt squash, one vector per clock.
      do_reset();
      //          en    v0    pc0    in0       v1    pc1    in1     rdy   valid pc     slot  rcyc  instret cycle halted cause
      vecs[0] = '{1'b1, 1'b0, 32'h0, 32'h0,    1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0};
      vecs[1] = '{1'b0, 1'b1, 32'h0, I_ADDI,   1'b1, 32'h4, I_ADD,  1'b1, 1'b1, 32'h0, 1'b0, 32'd0, 32'd2, 32'd1, 1'b0, 2'd0};
      vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0,    1'b0, 32'h0, 32'h0,  1'b1, 1'b1, 32'h4, 1'b1, 32'd0, 32'd2, 32'd2, 1'b0, 2'd0};
      vecs[3] = '{1'b0, 1'b1, 32'h40, I_EBREAK, 1'b1, 32'h44, I_ADDI, 1'b1, 1'b1, 32'h40, 1'b0, 32'd2, 32'd3, 32'd3, 1'b0, 2'd1};
      vecs[4] = '{1'b0, 1'b1, 32'h48, I_ADDI,  1'b0, 32'h0, 32'h0,  1'b0, 1'b1, 32'h40, 1'b0, 32'd2, 32'd3, 32'd3, 1'b0, 2'd1};
      vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0,    1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0, 32'd0, 32'd3, 32'd3, 1'b1, 2'd1};
      vecs[6] = '{1'b1, 1'b1, 32'h50, I_ADDI,  1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0, 32'd0, 32'd3, 32'd3, 1'b1, 2'd1};
      for (int i = 0; i < 7; i++) begin
         enable    = vecs[i].en;
         rec_ready = vecs[i].rdy;
         drive(vecs[i].v0, vecs[i].pc0, vecs[i].in0, vecs[i].v1, vecs[i].pc1, vecs[i].in1);
         tick();
         check($sformatf("v%0d_valid", i), 32'(rec_valid), 32'(vecs[i].e_valid));
         check($sformatf("v%0d_instret", i), instret, vecs[i].e_instret);
         check($sformatf("v%0d_cycle", i), cycle_count, vecs[i].e_cycle);
         check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halted));
         check($sformatf("v%0d_cause", i), 32'(halt_cause), 32'(vecs[i].e_cause));
         if (vecs[i].e_valid) begin
            check($sformatf("v%0d_pc", i), rec_pc, vecs[i].e_pc);
            check($sformatf("v%0d_slot", i), 32'(rec_slot), 32'(vecs[i].e_slot));
            check($sformatf("v%0d_rcyc", i), rec_cycle, vecs[i].e_rcyc);
            check($sformatf("v%0d_result", i), rec_result, vecs[i].e_pc + RES_OFS);
         end
      end

      // Timeout at max_cycles=10 with nothing retiring.
      do_reset();
      max_cycles = 32'd10;
      rec_ready  = 1'b1;
      start_run();
      repeat (9) tick();
      check("to_cycle9", cycle_count, 32'd9);
      check("to_cause_pre", 32'(halt_cause), 32'd0);
      tick();
      check("to_cycle10", cycle_count, 32'd10);
      check("to_cause", 32'(halt_cause), 32'd3);
      check("to_drain_halted", 32'(halted), 32'd0);
      tick();
      check("to_halted", 32'(halted), 32'd1);
      repeat (3) tick();
      check("to_frozen", cycle_count, 32'd10);
      check("to_instret", instret, 32'd0);

      // ECALL on the timeout cycle: halt wins.
      do_reset();
      max_cycles = 32'd10;
      start_run();
      repeat (9) tick();
      check("ec_cycle9", cycle_count, 32'd9);
      drive(1'b1, 32'h80, I_ECALL, 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      check("ec_cause", 32'(halt_cause), 32'd2);
      check("ec_cycle", cycle_count, 32'd10);
      check("ec_instret", instret, 32'd1);
      check("ec_pc", rec_pc, 32'h80);
      check("ec_rcyc", rec_cycle, 32'd9);
      check("ec_drain_halted", 32'(halted), 32'd0);
      rec_ready = 1'b1;
      tick();
      check("ec_halted", 32'(halted), 32'd1);
      check("ec_empty", 32'(rec_valid), 32'd0);

      // Overflow: five dual-retire cycles into an 8-entry FIFO with no consumer.
      do_reset();
      start_run();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h100 + 32'(8 * i), I_ADDI, 1'b1, 32'h104 + 32'(8 * i), I_ADD);
         if (i < 4) begin
            exp_q.push_back(32'h100 + 32'(8 * i));
            exp_q.push_back(32'h104 + 32'(8 * i));
         end
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      check("ovf_instret", instret, 32'd10);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_head", rec_pc, 32'h100);
      check("ovf_cycle", cycle_count, 32'd5);
      // Push into a full FIFO while the head pops: the push is still dropped.
      drive(1'b1, 32'h200, I_ADDI, 1'b0, 32'h0, 32'h0);
      rec_ready = 1'b1;
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      void'(exp_q.pop_front());
      check("full_pop_head", rec_pc, 32'h104);
      check("full_instret", instret, 32'd11);
      drain_check("ovf_drain");

      // One free entry with two pushes: slot0 kept, slot1 dropped.
      rec_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(8 * i), I_ADDI, 1'b1, 32'h304 + 32'(8 * i), I_ADD);
         exp_q.push_back(32'h300 + 32'(8 * i));
         exp_q.push_back(32'h304 + 32'(8 * i));
         tick();
      end
      drive(1'b1, 32'h318, I_ADDI, 1'b0, 32'h0, 32'h0);
      exp_q.push_back(32'h318);
      tick();
      drive(1'b1, 32'h320, I_ADDI, 1'b1, 32'h324, I_ADD);
      exp_q.push_back(32'h320);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      check("one_free_instret", instret, 32'd20);
      check("one_free_ovf", 32'(overflow), 32'd1);
      drain_check("one_free_drain");

      // Backpressure: random rec_ready under a single-slot stream, never overfilling.
      do_reset();
      start_run();
      stalled  = 1'b0;
      held_pc  = '0;
      held_res = '0;
      held_cyc = '0;
      nxt_pc   = 32'h1000;
      run_cyc  = '0;
      n_pushed = '0;
      for (int c = 0; c < 150; c++) begin
         if (stalled) begin
            check("bp_hold_pc", rec_pc, held_pc);
            check("bp_hold_res", rec_result, held_res);
            check("bp_hold_cyc", rec_cycle, held_cyc);
         end
         check("bp_valid", 32'(rec_valid), 32'(exp_q.size() != 0));
         v = (exp_q.size() < 8) && ($urandom_range(0, 3) != 0);
         rec_ready = 1'($urandom_range(0, 1));
         if (rec_valid && rec_ready && exp_q.size() != 0) begin
            check("bp_pc", rec_pc, exp_q.pop_front());
            check("bp_rcyc", rec_cycle, cyc_q.pop_front());
         end
         if (v) begin
            exp_q.push_back(nxt_pc);
            cyc_q.push_back(run_cyc);
            drive(1'b1, nxt_pc, I_ADDI, 1'b0, 32'h0, 32'h0);
            nxt_pc   = nxt_pc + 32'd4;
            n_pushed = n_pushed + 32'd1;
         end else begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
         end
         stalled  = rec_valid && !rec_ready;
         held_pc  = rec_pc;
         held_res = rec_result;
         held_cyc = rec_cycle;
         tick();
         run_cyc = run_cyc + 32'd1;
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      check("bp_cycle", cycle_count, run_cyc);
      check("bp_instret", instret, n_pushed);
      check("bp_ovf", 32'(overflow), 32'd0);
      cyc_q.delete();
      drain_check("bp_drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
